operand_select_pipe: RTL and testbench
======================================

Name: operand_select_pipe

Overview:
- Parametrised, pipelined successor to the datapath's hard-wired operand select mux.
- Selects one of NUM_INPUTS data inputs, one of NUM_CONSTS constant registers (runtime-writable) or the all-ones constant.
- Registers the result behind a valid/ready handshake.
- Sits between the register-file/immediate sources and the ALU operand port. It also flags illegal select codes instead of silently holding the old output.

Parameters:
- WIDTH, 17, operand width in bits.
- NUM_INPUTS, 3, number of data inputs (1..8).
- NUM_CONSTS, 3, number of programmable constant registers (1..8).
- SEL_W, 4, Selection width; must satisfy 2^SEL_W > NUM_INPUTS+NUM_CONSTS.
- CADDR_W, 2, constant write-address width; must satisfy 2^CADDR_W >= NUM_CONSTS.

Ports:
- Clock  in  1  single clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- InData  in  NUM_INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- Selection  in  SEL_W  source code; sampled with InValid.
- InValid  in  1  upstream request valid.
- InReady  out  1  block can accept a request this cycle.
- OutData  out  WIDTH  selected operand (registered).
- OutValid  out  1  OutData is valid.
- OutReady  in  1  downstream accepts OutData.
- ConstWrEn  in  1  constant register write strobe.
- ConstWrAddr  in  CADDR_W  constant register index.
- ConstWrData  in  WIDTH  constant write data.
- SelError  out  1  sticky illegal-selection flag.
- ErrClear  in  1  clears SelError.

Behaviour:
- Reset (async assert, sync release):
  - OutData=0, OutValid=0, SelError=0.
  - const[0]=95 (0x5F), const[1]=200 (0xC8), all other const[i]=0.
- Selection decode, with N = NUM_INPUTS and C = NUM_CONSTS:
  - 0..N-1 -> InData input k.
  - N..N+C-1 -> const[sel-N].
  - N+C -> all ones ({WIDTH{1'b1}}).
  - Any other code is illegal: the captured data is 0 and SelError is set.
- Handshake:
  - InReady = !OutValid || OutReady (combinational, no dependency on InValid).
  - Accept = InValid && InReady.
  - On accept: OutData <= decoded value, OutValid <= 1. Latency is exactly 1 cycle.
  - If OutValid && OutReady && !InValid: OutValid <= 0 and OutData holds its value.
  - If OutValid && !OutReady: OutData and OutValid hold, and InReady=0 (back-pressure). Full throughput of one result per cycle when OutReady stays high.
- Constant writes:
  - If ConstWrEn && ConstWrAddr < NUM_CONSTS: const[ConstWrAddr] <= ConstWrData at the clock edge.
  - Writes are independent of the handshake and allowed every cycle.
  - An out-of-range ConstWrAddr is ignored and sets SelError.
  - Write and accept in the same cycle that select the same constant: the accept captures the OLD value; the new value is visible from the next accept. No forwarding.
- SelError:
  - Set on an accepted illegal Selection or an out-of-range constant write.
  - Cleared by ErrClear. If set and clear happen in the same cycle, set wins.
  - Not set by illegal codes that are presented without being accepted.
- Reset mid-operation: a pending OutValid is dropped, constants revert to their defaults, and no partial state survives.
- Width rules:
  - Constants are stored full WIDTH.
  - The all-ones value is sized to WIDTH; no sign-extension logic.
- No combinational path from InData/Selection to OutData.

Decomposition:
- Shared package holds:
  - reset-default constants CONST0_RST=95 and CONST1_RST=200;
  - the helper localparams ALLONES_CODE = NUM_INPUTS+NUM_CONSTS and LAST_LEGAL_CODE.
- One natural sub-module, operand_const_regfile: NUM_CONSTS x WIDTH write-port registers with async reset defaults, an out-of-range flag output and a read mux by index.
- The top level holds the decode, the handshake register and the error flag.

Test Plan:
- Reset then idle: OutValid=0, OutData=0, SelError=0, InReady=1. Select codes 3 and 4 return 95 and 200; code 5 returns 0.
- Inputs 0x00011, 0x1FFFF, 0x0ABCD; Selection=0,1,2,6 on consecutive cycles with OutReady=1 -> OutData=0x00011, 0x1FFFF, 0x0ABCD, 0x1FFFF, one per cycle, each 1 cycle after accept.
- OutReady=0 for 3 cycles after the first result:
  - InReady=0 and OutData stable during the stall.
  - A queued Selection=1 is accepted on the cycle OutReady returns to 1.
  - No data is lost or duplicated.
- ConstWrEn, addr=2, data=0x12345, in the same cycle as accepting Selection=5 -> result 0. The next Selection=5 -> 0x12345.
- Selection=9 accepted -> OutData=0, SelError=1. The flag stays 1 across further legal transfers.
  - ErrClear together with a new illegal accept -> SelError stays 1.
  - ErrClear alone -> SelError=0.
- Reset_n pulsed low mid-stall with OutValid=1, after const[0] has been written to 7 -> OutValid=0 immediately (async). After release, Selection=3 returns 95.

Source files
------------

// File: rtl/operand_select_pipe_pkg.sv
// Shared defaults, reset constants and select-code helpers for the operand select pipe.
package operand_select_pipe_pkg;

  localparam int unsigned WIDTH_DEF      = 17;
  localparam int unsigned NUM_INPUTS_DEF = 3;
  localparam int unsigned NUM_CONSTS_DEF = 3;
  localparam int unsigned SEL_W_DEF      = 4;
  localparam int unsigned CADDR_W_DEF    = 2;

  localparam int unsigned CONST0_RST = 95;
  localparam int unsigned CONST1_RST = 200;

  localparam int unsigned ALLONES_CODE    = NUM_INPUTS_DEF + NUM_CONSTS_DEF;
  localparam int unsigned LAST_LEGAL_CODE = ALLONES_CODE;

  // Code of the all-ones source for an arbitrary input/constant split.
  function automatic int unsigned allones_code(int unsigned n_inputs, int unsigned n_consts);
    return n_inputs + n_consts;
  endfunction

endpackage

// File: rtl/operand_select_pipe_if.sv
// Request/response and constant-write bus of the operand select pipe.
interface operand_select_pipe_if
  import operand_select_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned CADDR_W    = CADDR_W_DEF
);
  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]            selection;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        const_wr_en;
  logic [CADDR_W-1:0]          const_wr_addr;
  logic [WIDTH-1:0]            const_wr_data;
  logic                        sel_error;
  logic                        err_clear;

  modport master (
    output in_data, selection, in_valid, out_ready,
           const_wr_en, const_wr_addr, const_wr_data, err_clear,
    input  in_ready, out_data, out_valid, sel_error
  );

  modport slave (
    input  in_data, selection, in_valid, out_ready,
           const_wr_en, const_wr_addr, const_wr_data, err_clear,
    output in_ready, out_data, out_valid, sel_error
  );
endinterface

// File: rtl/operand_const_regfile.sv
// Runtime-writable constant registers with reset defaults, out-of-range write flag and read mux.
module operand_const_regfile
  import operand_select_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned NUM_CONSTS = NUM_CONSTS_DEF,
  parameter int unsigned CADDR_W    = CADDR_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [CADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]   i_wr_data,
  input  logic [CADDR_W-1:0] i_rd_idx,
  output logic [WIDTH-1:0]   o_rd_data_c,
  output logic               o_wr_oor_c
);

  logic [WIDTH-1:0] r_const [NUM_CONSTS];

  assign o_wr_oor_c = i_wr_en && (32'(i_wr_addr) >= NUM_CONSTS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_CONSTS); i++) begin
        r_const[i] <= (i == 0) ? WIDTH'(CONST0_RST) :
                      (i == 1) ? WIDTH'(CONST1_RST) : '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CONSTS); i++) begin
        if (i_wr_en && (i_wr_addr == CADDR_W'(i))) r_const[i] <= i_wr_data;
      end
    end
  end

  // Read mux; indices past the last register return zero.
  always_comb begin
    o_rd_data_c = '0;
    for (int i = 0; i < int'(NUM_CONSTS); i++) begin
      if (i_rd_idx == CADDR_W'(i)) o_rd_data_c = r_const[i];
    end
  end

endmodule

// File: rtl/operand_select_pipe.sv
// Pipelined operand select: decodes input/constant/all-ones sources into a registered valid/ready stage.
module operand_select_pipe
  import operand_select_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int unsigned NUM_CONSTS = NUM_CONSTS_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned CADDR_W    = CADDR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  operand_select_pipe_if.slave  bus
);

  localparam int unsigned ALLONES    = allones_code(NUM_INPUTS, NUM_CONSTS);
  localparam int unsigned LAST_LEGAL = ALLONES;

  logic [WIDTH-1:0]   w_const_rd;
  logic [CADDR_W-1:0] w_cidx;
  logic               w_wr_oor;
  logic [WIDTH-1:0]   w_dec_data;
  logic               w_dec_illegal;
  logic               w_accept;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic               r_sel_error;

  assign w_cidx = CADDR_W'(bus.selection - SEL_W'(NUM_INPUTS));

  operand_const_regfile #(
    .WIDTH      (WIDTH),
    .NUM_CONSTS (NUM_CONSTS),
    .CADDR_W    (CADDR_W)
  ) u_const (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (bus.const_wr_en),
    .i_wr_addr   (bus.const_wr_addr),
    .i_wr_data   (bus.const_wr_data),
    .i_rd_idx    (w_cidx),
    .o_rd_data_c (w_const_rd),
    .o_wr_oor_c  (w_wr_oor)
  );

  // Source decode; illegal codes yield zero and raise the error flag on accept.
  always_comb begin
    w_dec_data    = '0;
    w_dec_illegal = 1'b0;
    if (bus.selection < SEL_W'(NUM_INPUTS)) begin
      for (int k = 0; k < int'(NUM_INPUTS); k++) begin
        if (bus.selection == SEL_W'(k)) w_dec_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end else if (bus.selection < SEL_W'(ALLONES)) begin
      w_dec_data = w_const_rd;
    end else if (bus.selection == SEL_W'(ALLONES)) begin
      w_dec_data = '1;
    end else begin
      w_dec_illegal = (bus.selection > SEL_W'(LAST_LEGAL));
    end
  end

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_data  <= w_dec_data;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky error: a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_error <= 1'b0;
    end else if ((w_accept && w_dec_illegal) || w_wr_oor) begin
      r_sel_error <= 1'b1;
    end else if (bus.err_clear) begin
      r_sel_error <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.sel_error = r_sel_error;

endmodule

// File: tb/tb_operand_select_pipe.sv
// Randomised and directed bench for operand_select_pipe against a transaction-level reference model.
module tb_operand_select_pipe;
  import operand_select_pipe_pkg::*;

  localparam int unsigned W  = 17;
  localparam int unsigned N  = 3;
  localparam int unsigned C  = 3;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_select_pipe_if #(.WIDTH(W), .NUM_INPUTS(N), .SEL_W(SW), .CADDR_W(CW)) bus ();

  operand_select_pipe #(
    .WIDTH(W), .NUM_INPUTS(N), .NUM_CONSTS(C), .SEL_W(SW), .CADDR_W(CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the block should present after each clock edge.
  int unsigned m_const [C];
  int unsigned m_data;
  bit          m_valid;
  bit          m_err;

  localparam int unsigned ALL1 = (1 << W) - 1;

  // Returns the operand for a code, or -1 for an illegal code.
  function automatic longint ref_op(int unsigned sel, logic [N*W-1:0] din);
    if (sel < N)           return longint'(din[sel*W +: W]);
    else if (sel < N + C)  return longint'(m_const[sel-N]);
    else if (sel == N + C) return longint'(ALL1);
    else                   return -1;
  endfunction

  task automatic model_reset();
    m_const[0] = 95; m_const[1] = 200; m_const[2] = 0;
    m_data = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.const_wr_en = 0; bus.err_clear = 0; bus.out_ready = 1;
    bus.const_wr_addr = '0; bus.const_wr_data = '0;
  endtask

  // Advance one clock, updating the reference from the inputs presented before the edge.
  task automatic step();
    bit     acc, wr_in_range, wr_bad, clr, ordy;
    longint r;
    int unsigned waddr, wdata;
    acc         = bus.in_valid && (!m_valid || bus.out_ready);
    r           = ref_op(32'(bus.selection), bus.in_data);
    waddr       = 32'(bus.const_wr_addr);
    wdata       = 32'(bus.const_wr_data);
    wr_in_range = bus.const_wr_en && (waddr < C);
    wr_bad      = bus.const_wr_en && (waddr >= C);
    clr         = bus.err_clear;
    ordy        = bus.out_ready;
    @(posedge clk); #1;
    if (acc) begin
      m_data  = (r < 0) ? 0 : int'(r);
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    if (wr_in_range) m_const[waddr] = wdata;
    if ((acc && r < 0) || wr_bad) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic test_reset();
    int unsigned exp_v [3];
    exp_v[0] = 95; exp_v[1] = 200; exp_v[2] = 0;
    rst_n = 0; idle(); bus.selection = '0; bus.in_data = '0; model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== '0) $display("FAIL reset_data got %h exp 0", bus.out_data); else n_pass++;
    n_checks++; if (bus.sel_error !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.sel_error); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.selection = SW'(3 + i);
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || 32'(bus.out_data) !== exp_v[i])
        $display("FAIL reset_const sel=%0d got %h/%b exp %h/1", 3 + i, bus.out_data, bus.out_valid, exp_v[i]);
      else n_pass++;
    end
    idle(); step();
  endtask

  task automatic test_stream();
    int unsigned sels [4];
    int unsigned exp_v [4];
    sels[0] = 0; sels[1] = 1; sels[2] = 2; sels[3] = 6;
    exp_v[0] = 32'h00011; exp_v[1] = 32'h1FFFF; exp_v[2] = 32'h0ABCD; exp_v[3] = 32'h1FFFF;
    bus.in_data = {W'(32'h0ABCD), W'(32'h1FFFF), W'(32'h00011)};
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.selection = SW'(sels[i]);
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || 32'(bus.out_data) !== exp_v[i] || 32'(bus.out_data) !== m_data)
        $display("FAIL stream sel=%0d got %h exp %h", sels[i], bus.out_data, exp_v[i]);
      else n_pass++;
    end
    idle(); step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drain got %b exp 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    logic [W-1:0] held;
    bus.in_valid = 1; bus.selection = SW'(0); step();
    held = bus.out_data;
    bus.selection = SW'(1); bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready cyc=%0d got %b exp 0", i, bus.in_ready); else n_pass++;
      step();
      n_checks++;
      if (bus.out_data !== held || bus.out_valid !== 1'b1 || 32'(held) !== 32'h00011)
        $display("FAIL stall_hold cyc=%0d got %h exp %h", i, bus.out_data, W'(32'h00011));
      else n_pass++;
    end
    bus.out_ready = 1; #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release got %b exp 1", bus.in_ready); else n_pass++;
    step();
    bus.in_valid = 0;
    n_checks++; if (32'(bus.out_data) !== 32'h1FFFF || bus.out_valid !== 1'b1) $display("FAIL stall_next got %h exp 1ffff", bus.out_data); else n_pass++;
    step();
    n_checks++; if (bus.out_valid !== 1'b0 || 32'(bus.out_data) !== 32'h1FFFF) $display("FAIL stall_nodup got %b/%h exp 0/1ffff", bus.out_valid, bus.out_data); else n_pass++;
  endtask

  task automatic test_const_hazard();
    bus.in_valid = 1; bus.selection = SW'(5);
    bus.const_wr_en = 1; bus.const_wr_addr = CW'(2); bus.const_wr_data = W'(32'h12345);
    step();
    bus.const_wr_en = 0;
    n_checks++; if (bus.out_data !== '0) $display("FAIL hazard_old got %h exp 0", bus.out_data); else n_pass++;
    step();
    n_checks++; if (32'(bus.out_data) !== 32'h12345) $display("FAIL hazard_new got %h exp 12345", bus.out_data); else n_pass++;
    idle(); step();
  endtask

  task automatic test_error();
    bus.in_valid = 1; bus.selection = SW'(9); step();
    n_checks++; if (bus.out_data !== '0 || bus.sel_error !== 1'b1) $display("FAIL err_set got %h/%b exp 0/1", bus.out_data, bus.sel_error); else n_pass++;
    bus.selection = SW'(1); step(); step();
    n_checks++; if (bus.sel_error !== 1'b1) $display("FAIL err_sticky got %b exp 1", bus.sel_error); else n_pass++;
    bus.selection = SW'(10); bus.err_clear = 1; step();
    n_checks++; if (bus.sel_error !== 1'b1) $display("FAIL err_setwins got %b exp 1", bus.sel_error); else n_pass++;
    bus.in_valid = 0; step();
    bus.err_clear = 0;
    n_checks++; if (bus.sel_error !== 1'b0) $display("FAIL err_clear got %b exp 0", bus.sel_error); else n_pass++;
    bus.in_valid = 1; bus.selection = SW'(0); step();
    bus.out_ready = 0; bus.selection = SW'(12); step(); step();
    n_checks++; if (bus.sel_error !== 1'b0) $display("FAIL err_unaccepted got %b exp 0", bus.sel_error); else n_pass++;
    idle(); bus.const_wr_en = 1; bus.const_wr_addr = CW'(3); bus.const_wr_data = W'(32'h1); step();
    bus.const_wr_en = 0;
    n_checks++; if (bus.sel_error !== 1'b1 || m_const[0] !== 95) $display("FAIL err_wr_oor got %b exp 1", bus.sel_error); else n_pass++;
    bus.err_clear = 1; step(); idle();
  endtask

  task automatic test_reset_mid();
    bus.const_wr_en = 1; bus.const_wr_addr = CW'(0); bus.const_wr_data = W'(7); step();
    bus.const_wr_en = 0; bus.in_valid = 1; bus.selection = SW'(3); step();
    n_checks++; if (32'(bus.out_data) !== 7) $display("FAIL mid_wr got %h exp 7", bus.out_data); else n_pass++;
    bus.out_ready = 0; step();
    #2 rst_n = 0; #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_async got %b exp 0", bus.out_valid); else n_pass++;
    model_reset(); idle();
    @(negedge clk); rst_n = 1;
    bus.in_valid = 1; bus.selection = SW'(3); step();
    n_checks++; if (32'(bus.out_data) !== 95) $display("FAIL mid_default got %h exp 5f", bus.out_data); else n_pass++;
    idle(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.in_data       = {W'($urandom), W'($urandom), W'($urandom)};
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.selection     = SW'($urandom_range(0, 8));
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      bus.const_wr_en   = ($urandom_range(0, 3) == 0);
      bus.const_wr_addr = CW'($urandom);
      bus.const_wr_data = W'($urandom);
      bus.err_clear     = ($urandom_range(0, 4) == 0);
      #1;
      n_checks++;
      if (bus.in_ready !== (!m_valid || bus.out_ready)) $display("FAIL rnd_ready i=%0d got %b", i, bus.in_ready);
      else n_pass++;
      step();
      n_checks++;
      if (bus.out_valid !== m_valid || 32'(bus.out_data) !== m_data || bus.sel_error !== m_err)
        $display("FAIL rnd_out i=%0d got %b/%h/%b exp %b/%h/%b", i, bus.out_valid, bus.out_data,
                 bus.sel_error, m_valid, m_data, m_err);
      else n_pass++;
    end
    idle(); step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back_stall();
    test_const_hazard();
    test_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
